// File: rtl/dallanma_pkg.sv
// Shared types and constants for the branch resolution unit: FSM encoding,
// branch record layout and small helpers for packing and checking records.
package dallanma_pkg;

   typedef enum logic [0:0] {
      NORMAL  = 1'b0,
      TEMIZLE = 1'b1
   } durum_e;

   localparam int ADRES_W     = 32;
   localparam int PS_LSB      = 0;
   localparam int ATLADI_BIT  = 32;
   localparam int HEDEF_LSB   = 33;
   localparam int KAYIT_W     = 65;
   localparam int BUYRUK_BOYU = 4;

   function automatic logic [KAYIT_W-1:0] kayit_paketle(
      input logic [ADRES_W-1:0] ps,
      input logic               atladi,
      input logic [ADRES_W-1:0] hedef
   );
      logic [KAYIT_W-1:0] k;
      k                            = '0;
      k[PS_LSB +: ADRES_W]         = ps;
      k[ATLADI_BIT]                = atladi;
      k[HEDEF_LSB +: ADRES_W]      = hedef;
      return k;
   endfunction

   // A taken/taken pair still mispredicts when the predicted target was wrong.
   function automatic logic yanlis_mi(
      input logic [KAYIT_W-1:0] kayit,
      input logic               atladi,
      input logic [ADRES_W-1:0] hedef
   );
      logic tahmin;
      tahmin = kayit[ATLADI_BIT];
      return (tahmin != atladi) ||
             (tahmin && atladi && (kayit[HEDEF_LSB +: ADRES_W] != hedef));
   endfunction

endpackage

// File: rtl/dallanma_cozucu_if.sv
// Fetch/execute/predictor-update bundle of the branch resolution unit.
// slave is the resolution unit itself, master is whoever drives fetch and execute.
interface dallanma_cozucu_if #(
   parameter int SAYAC_W = 16
);
   logic               kaydet_gecerli_i;
   logic [31:0]        kaydet_ps_i;
   logic               kaydet_atladi_i;
   logic [31:0]        kaydet_hedef_i;
   logic               kaydet_hazir_o;

   logic               cozum_gecerli_i;
   logic [31:0]        cozum_ps_i;
   logic               cozum_atladi_i;
   logic [31:0]        cozum_hedef_i;

   logic               guncelle_gecerli_o;
   logic               guncelle_atladi_o;
   logic [31:0]        guncelle_ps_o;
   logic               yanlis_tahmin_o;
   logic [31:0]        duzelt_ps_o;
   logic               hata_o;
   logic [SAYAC_W-1:0] dogru_sayac_o;
   logic [SAYAC_W-1:0] yanlis_sayac_o;

   modport slave (
      input  kaydet_gecerli_i, kaydet_ps_i, kaydet_atladi_i, kaydet_hedef_i,
      input  cozum_gecerli_i, cozum_ps_i, cozum_atladi_i, cozum_hedef_i,
      output kaydet_hazir_o, guncelle_gecerli_o, guncelle_atladi_o, guncelle_ps_o,
      output yanlis_tahmin_o, duzelt_ps_o, hata_o, dogru_sayac_o, yanlis_sayac_o
   );

   modport master (
      output kaydet_gecerli_i, kaydet_ps_i, kaydet_atladi_i, kaydet_hedef_i,
      output cozum_gecerli_i, cozum_ps_i, cozum_atladi_i, cozum_hedef_i,
      input  kaydet_hazir_o, guncelle_gecerli_o, guncelle_atladi_o, guncelle_ps_o,
      input  yanlis_tahmin_o, duzelt_ps_o, hata_o, dogru_sayac_o, yanlis_sayac_o
   );
endinterface

// File: rtl/dallanma_fifo.sv
// In-order FIFO of in-flight branch records with a one-cycle flush that
// discards every entry, including a push arriving in the same cycle.
module dallanma_fifo #(
   parameter int DERINLIK = 4,
   parameter int KAYIT_W  = 65
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic               pop,
   input  logic               flush,
   input  logic [KAYIT_W-1:0] push_data,
   output logic               full,
   output logic               empty,
   output logic [KAYIT_W-1:0] head
);
   localparam int PTR_W = $clog2(DERINLIK);
   localparam int CNT_W = PTR_W + 1;

   logic [KAYIT_W-1:0] mem [DERINLIK];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               do_push;
   logic               do_pop;

   assign full    = (count == CNT_W'(DERINLIK));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   // NOTE: the record storage has no reset; empty gates every use of a stale entry.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dallanma_cozucu.sv
// Branch resolution unit: checks resolved branches against the oldest predicted
// record, drives the predictor update bus and redirects fetch on a misprediction.
module dallanma_cozucu
   import dallanma_pkg::*;
#(
   parameter int DERINLIK = 4,
   parameter int SAYAC_W  = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   dallanma_cozucu_if.slave   bus
);
   durum_e               durum_q;
   durum_e               durum_d;
   logic                 hazir_q;
   logic                 hazir;
   logic                 kabul;
   logic                 itme;
   logic                 cozum_aktif;
   logic                 eslesme;
   logic                 yanlis;
   logic                 dolu;
   logic                 bos;
   logic [KAYIT_W-1:0]   bas_kayit;
   logic [KAYIT_W-1:0]   yeni_kayit;

   logic                 guncelle_gecerli_q;
   logic                 guncelle_atladi_q;
   logic [ADRES_W-1:0]   guncelle_ps_q;
   logic                 yanlis_q;
   logic [ADRES_W-1:0]   duzelt_q;
   logic                 hata_q;
   logic [SAYAC_W-1:0]   dogru_q;
   logic [SAYAC_W-1:0]   yanlis_sayac_q;

   assign yeni_kayit = kayit_paketle(bus.kaydet_ps_i, bus.kaydet_atladi_i, bus.kaydet_hedef_i);
   // A push in the mispredicting cycle is wrong-path and must not enter the FIFO.
   assign itme       = kabul && !yanlis;

   dallanma_fifo #(
      .DERINLIK (DERINLIK),
      .KAYIT_W  (KAYIT_W)
   ) u_fifo (
      .clk       (clk_i),
      .rst_n     (rst_i),
      .push      (itme),
      .pop       (eslesme),
      .flush     (yanlis),
      .push_data (yeni_kayit),
      .full      (dolu),
      .empty     (bos),
      .head      (bas_kayit)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) durum_q <= NORMAL;
      else        durum_q <= durum_d;
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      durum_d     = durum_q;
      cozum_aktif = 1'b0;
      eslesme     = 1'b0;
      yanlis      = 1'b0;
      hazir       = hazir_q && (durum_q == NORMAL) && !dolu;
      kabul       = hazir && bus.kaydet_gecerli_i;
      case (durum_q)
         NORMAL: begin
            cozum_aktif = bus.cozum_gecerli_i;
            eslesme     = cozum_aktif && !bos &&
                          (bas_kayit[PS_LSB +: ADRES_W] == bus.cozum_ps_i);
            yanlis      = eslesme &&
                          yanlis_mi(bas_kayit, bus.cozum_atladi_i, bus.cozum_hedef_i);
            if (yanlis) durum_d = TEMIZLE;
         end
         TEMIZLE: durum_d = NORMAL;
         default: durum_d = NORMAL;
      endcase
   end

   // hazir_q keeps kaydet_hazir_o low during reset and raises it on the first clock after.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         hazir_q            <= 1'b0;
         guncelle_gecerli_q <= 1'b0;
         guncelle_atladi_q  <= 1'b0;
         guncelle_ps_q      <= '0;
         yanlis_q           <= 1'b0;
         duzelt_q           <= '0;
         hata_q             <= 1'b0;
      end else begin
         hazir_q            <= 1'b1;
         guncelle_gecerli_q <= eslesme;
         guncelle_atladi_q  <= eslesme && bus.cozum_atladi_i;
         guncelle_ps_q      <= eslesme ? bus.cozum_ps_i : '0;
         yanlis_q           <= yanlis;
         if (!yanlis)                 duzelt_q <= '0;
         else if (bus.cozum_atladi_i) duzelt_q <= bus.cozum_hedef_i;
         else                         duzelt_q <= bus.cozum_ps_i + ADRES_W'(BUYRUK_BOYU);
         if (cozum_aktif && !eslesme) hata_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         dogru_q        <= '0;
         yanlis_sayac_q <= '0;
      end else if (eslesme) begin
         if (yanlis) begin
            if (yanlis_sayac_q != '1) yanlis_sayac_q <= yanlis_sayac_q + SAYAC_W'(1);
         end else begin
            if (dogru_q != '1) dogru_q <= dogru_q + SAYAC_W'(1);
         end
      end
   end

   assign bus.kaydet_hazir_o     = hazir;
   assign bus.guncelle_gecerli_o = guncelle_gecerli_q;
   assign bus.guncelle_atladi_o  = guncelle_atladi_q;
   assign bus.guncelle_ps_o      = guncelle_ps_q;
   assign bus.yanlis_tahmin_o    = yanlis_q;
   assign bus.duzelt_ps_o        = duzelt_q;
   assign bus.hata_o             = hata_q;
   assign bus.dogru_sayac_o      = dogru_q;
   assign bus.yanlis_sayac_o     = yanlis_sayac_q;

endmodule

// File: tb/tb_dallanma_cozucu.sv
// Directed bench for dallanma_cozucu; a second narrow-counter instance exercises saturation.
module tb_dallanma_cozucu;

   logic clk;
   logic rst_i;
   int   tests;
   int   fails;

   dallanma_cozucu_if #(.SAYAC_W(16)) bus ();
   dallanma_cozucu_if #(.SAYAC_W(3))  bus_k ();

   dallanma_cozucu #(.DERINLIK(4), .SAYAC_W(16)) dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bus)
   );

   dallanma_cozucu #(.DERINLIK(4), .SAYAC_W(3)) dut_k (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bus_k)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bosta();
      bus.kaydet_gecerli_i   = 1'b0;
      bus.kaydet_ps_i        = '0;
      bus.kaydet_atladi_i    = 1'b0;
      bus.kaydet_hedef_i     = '0;
      bus.cozum_gecerli_i    = 1'b0;
      bus.cozum_ps_i         = '0;
      bus.cozum_atladi_i     = 1'b0;
      bus.cozum_hedef_i      = '0;
      bus_k.kaydet_gecerli_i = 1'b0;
      bus_k.kaydet_ps_i      = '0;
      bus_k.kaydet_atladi_i  = 1'b0;
      bus_k.kaydet_hedef_i   = '0;
      bus_k.cozum_gecerli_i  = 1'b0;
      bus_k.cozum_ps_i       = '0;
      bus_k.cozum_atladi_i   = 1'b0;
      bus_k.cozum_hedef_i    = '0;
   endtask

   task automatic kaydet_sur(input logic [31:0] ps, input logic t, input logic [31:0] h);
      bus.kaydet_gecerli_i = 1'b1;
      bus.kaydet_ps_i      = ps;
      bus.kaydet_atladi_i  = t;
      bus.kaydet_hedef_i   = h;
   endtask

   task automatic coz_sur(input logic [31:0] ps, input logic t, input logic [31:0] h);
      bus.cozum_gecerli_i = 1'b1;
      bus.cozum_ps_i      = ps;
      bus.cozum_atladi_i  = t;
      bus.cozum_hedef_i   = h;
   endtask

   task automatic kaydet(input logic [31:0] ps, input logic t, input logic [31:0] h);
      kaydet_sur(ps, t, h);
      tick();
      bosta();
   endtask

   task automatic coz(input logic [31:0] ps, input logic t, input logic [31:0] h);
      coz_sur(ps, t, h);
      tick();
      bosta();
   endtask

   task automatic sifirla();
      rst_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_i = 1'b1;
      tick();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_i = 1'b0;
      bosta();

      // Reset state
      #3;
      check("rst_hazir", bus.kaydet_hazir_o, 0);
      check("rst_guncelle", bus.guncelle_gecerli_o, 0);
      check("rst_yanlis", bus.yanlis_tahmin_o, 0);
      check("rst_hata", bus.hata_o, 0);
      check("rst_dogru", bus.dogru_sayac_o, 0);
      @(negedge clk);
      rst_i = 1'b1;
      tick();
      check("hazir_after_rst", bus.kaydet_hazir_o, 1);

      // 1: correct taken prediction
      kaydet(32'h100, 1'b1, 32'h140);
      coz(32'h100, 1'b1, 32'h140);
      check("t1_guncelle", bus.guncelle_gecerli_o, 1);
      check("t1_atladi", bus.guncelle_atladi_o, 1);
      check("t1_ps", bus.guncelle_ps_o, 32'h100);
      check("t1_yanlis", bus.yanlis_tahmin_o, 0);
      check("t1_dogru", bus.dogru_sayac_o, 1);
      tick();
      check("t1_strobe_low", bus.guncelle_gecerli_o, 0);

      // 2: NT predicted, taken actual -> flush of the younger record
      kaydet(32'h200, 1'b0, 32'h0);
      kaydet(32'h204, 1'b1, 32'h300);
      coz(32'h200, 1'b1, 32'h280);
      check("t2_yanlis", bus.yanlis_tahmin_o, 1);
      check("t2_duzelt", bus.duzelt_ps_o, 32'h280);
      check("t2_guncelle_atladi", bus.guncelle_atladi_o, 1);
      check("t2_hazir_temizle", bus.kaydet_hazir_o, 0);
      check("t2_hata_clear", bus.hata_o, 0);
      tick();
      check("t2_yanlis_pulse", bus.yanlis_tahmin_o, 0);
      check("t2_hazir_back", bus.kaydet_hazir_o, 1);
      coz(32'h204, 1'b1, 32'h300);
      check("t2_flushed_hata", bus.hata_o, 1);
      check("t2_flushed_no_upd", bus.guncelle_gecerli_o, 0);

      // 3: T predicted, NT actual; same-cycle push is discarded
      sifirla();
      kaydet(32'h10, 1'b1, 32'h50);
      kaydet_sur(32'h18, 1'b0, 32'h0);
      coz_sur(32'h10, 1'b0, 32'h0);
      tick();
      bosta();
      check("t3_duzelt", bus.duzelt_ps_o, 32'h14);
      check("t3_g_atladi", bus.guncelle_atladi_o, 0);
      check("t3_yanlis_sayac", bus.yanlis_sayac_o, 1);
      check("t3_dogru", bus.dogru_sayac_o, 0);
      tick();
      coz(32'h18, 1'b0, 32'h0);
      check("t3_push_dropped", bus.hata_o, 1);

      // 4: full FIFO, pop with simultaneous push rejected
      sifirla();
      kaydet(32'h400, 1'b1, 32'h500);
      kaydet(32'h404, 1'b0, 32'h0);
      kaydet(32'h408, 1'b0, 32'h0);
      check("t4_hazir_3", bus.kaydet_hazir_o, 1);
      kaydet(32'h40C, 1'b1, 32'h600);
      check("t4_full", bus.kaydet_hazir_o, 0);
      coz_sur(32'h400, 1'b1, 32'h500);
      kaydet_sur(32'h410, 1'b0, 32'h0);
      #1;
      check("t4_no_bypass", bus.kaydet_hazir_o, 0);
      tick();
      bosta();
      check("t4_hazir_next", bus.kaydet_hazir_o, 1);
      check("t4_guncelle", bus.guncelle_gecerli_o, 1);
      coz(32'h404, 1'b0, 32'h0);
      coz(32'h408, 1'b0, 32'h0);
      coz(32'h40C, 1'b1, 32'h600);
      check("t4_dogru", bus.dogru_sayac_o, 4);
      check("t4_yanlis_sayac", bus.yanlis_sayac_o, 0);
      check("t4_hata_before", bus.hata_o, 0);
      coz(32'h410, 1'b0, 32'h0);
      check("t4_empty_hata", bus.hata_o, 1);
      check("t4_empty_no_upd", bus.guncelle_gecerli_o, 0);

      // 5: head PC mismatch pops nothing; reset during TEMIZLE
      sifirla();
      check("t5_hata_rst", bus.hata_o, 0);
      kaydet(32'h20, 1'b0, 32'h0);
      coz(32'h24, 1'b0, 32'h0);
      check("t5_mismatch_hata", bus.hata_o, 1);
      check("t5_mismatch_no_upd", bus.guncelle_gecerli_o, 0);
      coz(32'h20, 1'b0, 32'h0);
      check("t5_head_kept", bus.guncelle_gecerli_o, 1);
      check("t5_head_ps", bus.guncelle_ps_o, 32'h20);
      kaydet(32'h30, 1'b1, 32'h60);
      coz(32'h30, 1'b0, 32'h0);
      check("t5_yanlis", bus.yanlis_tahmin_o, 1);
      #2;
      rst_i = 1'b0;
      #1;
      check("t5_rst_yanlis", bus.yanlis_tahmin_o, 0);
      check("t5_rst_duzelt", bus.duzelt_ps_o, 0);
      check("t5_rst_guncelle", bus.guncelle_gecerli_o, 0);
      check("t5_rst_hazir", bus.kaydet_hazir_o, 0);
      check("t5_rst_hata", bus.hata_o, 0);
      check("t5_rst_dogru", bus.dogru_sayac_o, 0);
      @(negedge clk);
      rst_i = 1'b1;
      tick();
      check("t5_no_redirect", bus.yanlis_tahmin_o, 0);
      check("t5_hazir", bus.kaydet_hazir_o, 1);

      // 6: PC wrap on not-taken correction; taken target mismatch
      kaydet(32'hFFFF_FFFC, 1'b1, 32'h8);
      coz(32'hFFFF_FFFC, 1'b0, 32'h0);
      check("t6_wrap_yanlis", bus.yanlis_tahmin_o, 1);
      check("t6_wrap_duzelt", bus.duzelt_ps_o, 32'h0);
      tick();
      kaydet(32'h500, 1'b1, 32'h540);
      coz(32'h500, 1'b1, 32'h544);
      check("t6_hedef_yanlis", bus.yanlis_tahmin_o, 1);
      check("t6_hedef_duzelt", bus.duzelt_ps_o, 32'h544);
      check("t6_yanlis_sayac", bus.yanlis_sayac_o, 2);
      tick();

      // Saturation on the 3-bit instance, with push and pop in the same cycle
      bus_k.kaydet_gecerli_i = 1'b1;
      bus_k.kaydet_ps_i      = 32'h1000;
      tick();
      for (int i = 0; i < 9; i++) begin
         bus_k.kaydet_gecerli_i = 1'b1;
         bus_k.kaydet_ps_i      = 32'h1004 + 32'(4 * i);
         bus_k.cozum_gecerli_i  = 1'b1;
         bus_k.cozum_ps_i       = 32'h1000 + 32'(4 * i);
         tick();
         if (i == 3) check("sat_mid", bus_k.dogru_sayac_o, 4);
      end
      bosta();
      check("sat_dogru", bus_k.dogru_sayac_o, 7);
      check("sat_hata", bus_k.hata_o, 0);
      check("sat_occupancy", bus_k.kaydet_hazir_o, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
